// File: rtl/tboom_rmt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tboom_rmt_pkg
// Purpose  : Shared definitions for the rename-map checkpoint controller:
//            recovery FSM state encoding and default checkpoint depth.
// Contents : DEFAULT_CHECKPOINT_DEPTH - default number of checkpoint slots
//            ckpt_state_e             - controller FSM states
// Revision : 1.0 - initial release
// ============================================================================
package tboom_rmt_pkg;

    localparam int unsigned DEFAULT_CHECKPOINT_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_RESTORE = 2'd1,
        ST_DRAIN   = 2'd2
    } ckpt_state_e;

endpackage : tboom_rmt_pkg
`default_nettype wire

// File: rtl/tboom_checkpoint_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tboom_checkpoint_ctrl
// Purpose  : Allocates rename-map checkpoints to branches as a ring, retires
//            them in program order once resolved, and sequences rename-map
//            recovery (restore pulse + stall) on a mispredict.
// Ports    : clk, rst                    - clock, async active-high reset
//            br_alloc_valid/ready/id     - checkpoint allocation handshake
//            br_resolve_valid/id/mispredict - branch resolution event
//            rn_checkpoint, rn_restore, rn_restore_pos, rn_stall
//                                        - rename unit control
//            busy_mask, free_count       - slot occupancy status
//            err_bad_resolve             - sticky bad-resolve flag
// Revision : 1.0 - initial release
// ============================================================================
module tboom_checkpoint_ctrl
    import tboom_rmt_pkg::*;
#(
    parameter int CHECKPOINT_DEPTH = DEFAULT_CHECKPOINT_DEPTH,
    parameter int CKPT_ID_WIDTH    = $clog2(CHECKPOINT_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        br_alloc_valid,
    output logic                        br_alloc_ready,
    output logic [CKPT_ID_WIDTH-1:0]    br_alloc_id,
    input  logic                        br_resolve_valid,
    input  logic [CKPT_ID_WIDTH-1:0]    br_resolve_id,
    input  logic                        br_resolve_mispredict,
    output logic                        rn_checkpoint,
    output logic                        rn_restore,
    output logic [CKPT_ID_WIDTH-1:0]    rn_restore_pos,
    output logic                        rn_stall,
    output logic [CHECKPOINT_DEPTH-1:0] busy_mask,
    output logic [CKPT_ID_WIDTH:0]      free_count,
    output logic                        err_bad_resolve
);

    localparam logic [CKPT_ID_WIDTH:0]   C_DEPTH   = CHECKPOINT_DEPTH[CKPT_ID_WIDTH:0];
    localparam logic [CKPT_ID_WIDTH-1:0] C_ID_ONE  = {{(CKPT_ID_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CKPT_ID_WIDTH-1:0] C_ID_ZERO = '0;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    ckpt_state_e                 r_state;
    ckpt_state_e                 w_state_next;
    logic [CKPT_ID_WIDTH-1:0]    r_head;
    logic [CKPT_ID_WIDTH-1:0]    r_tail;
    logic [CKPT_ID_WIDTH-1:0]    r_restore_pos;
    logic [CHECKPOINT_DEPTH-1:0] r_busy;
    logic [CHECKPOINT_DEPTH-1:0] r_resolved;
    logic                        r_err;

    // ------------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------------
    logic                        w_normal;
    logic                        w_res_hit;
    logic                        w_mispredict_req;
    logic                        w_kill;
    logic                        w_correct;
    logic                        w_bad;
    logic                        w_grant;
    logic                        w_retire;
    logic                        w_kill_head;
    logic [CKPT_ID_WIDTH:0]      w_busy_cnt;
    logic [CKPT_ID_WIDTH-1:0]    w_span;
    logic [CHECKPOINT_DEPTH-1:0] w_kill_mask;
    logic [CHECKPOINT_DEPTH-1:0] w_busy_next;
    logic [CHECKPOINT_DEPTH-1:0] w_resolved_next;
    logic [CKPT_ID_WIDTH-1:0]    w_head_next;
    logic [CKPT_ID_WIDTH-1:0]    w_tail_next;

    assign w_normal         = (r_state == ST_NORMAL);
    assign w_res_hit        = r_busy[br_resolve_id];
    // Any mispredict, even a bogus one, blocks allocation for the cycle.
    assign w_mispredict_req = br_resolve_valid && br_resolve_mispredict;
    assign w_kill           = w_normal && w_mispredict_req && w_res_hit;
    assign w_correct        = w_normal && br_resolve_valid && !br_resolve_mispredict && w_res_hit;
    assign w_bad            = w_normal && br_resolve_valid && !w_res_hit;
    assign w_grant          = br_alloc_valid && br_alloc_ready;
    assign w_retire         = r_busy[r_head] && r_resolved[r_head];
    // Killing the head slot empties the ring, so head must stay put to meet tail.
    assign w_kill_head      = w_kill && (br_resolve_id == r_head);

    always_comb begin
        w_busy_cnt = '0;
        for (int i = 0; i < CHECKPOINT_DEPTH; i++) begin
            w_busy_cnt = w_busy_cnt + {{CKPT_ID_WIDTH{1'b0}}, r_busy[i]};
        end
    end

    // Slots from the mispredicting id up to tail-1, ring-relative. A zero span
    // means tail==id, which for a busy id only happens on a full ring with the
    // head mispredicting: every slot is younger-or-equal and gets flushed.
    assign w_span = r_tail - br_resolve_id;

    always_comb begin
        w_kill_mask = '0;
        for (int i = 0; i < CHECKPOINT_DEPTH; i++) begin
            w_kill_mask[i] = (w_span == C_ID_ZERO) ||
                             ((CKPT_ID_WIDTH'(i) - br_resolve_id) < w_span);
        end
    end

    // ------------------------------------------------------------------------
    // Ring next-state: resolve mark, retire, flush, then grant
    // ------------------------------------------------------------------------
    always_comb begin
        w_busy_next     = r_busy;
        w_resolved_next = r_resolved;
        w_head_next     = r_head;
        w_tail_next     = r_tail;

        if (w_correct) begin
            w_resolved_next[br_resolve_id] = 1'b1;
        end

        if (w_retire) begin
            w_busy_next[r_head]     = 1'b0;
            w_resolved_next[r_head] = 1'b0;
            if (!w_kill_head) begin
                w_head_next = r_head + C_ID_ONE;
            end
        end

        if (w_kill) begin
            w_busy_next = w_busy_next & ~w_kill_mask;
            w_tail_next = br_resolve_id;
        end

        if (w_grant) begin
            w_busy_next[r_tail]     = 1'b1;
            w_resolved_next[r_tail] = 1'b0;
            w_tail_next             = r_tail + C_ID_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_busy        <= '0;
            r_resolved    <= '0;
            r_restore_pos <= '0;
            r_err         <= 1'b0;
        end else begin
            r_head     <= w_head_next;
            r_tail     <= w_tail_next;
            r_busy     <= w_busy_next;
            r_resolved <= w_resolved_next;
            if (w_kill) begin
                r_restore_pos <= br_resolve_id;
            end
            if (w_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Recovery FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        br_alloc_ready = 1'b0;
        rn_restore     = 1'b0;
        rn_restore_pos = '0;
        rn_stall       = 1'b0;

        case (r_state)
            ST_NORMAL: begin
                br_alloc_ready = (w_busy_cnt != C_DEPTH) && !w_mispredict_req && !rst;
                if (w_kill) begin
                    w_state_next = ST_RESTORE;
                end
            end
            ST_RESTORE: begin
                rn_restore     = !rst;
                rn_restore_pos = rst ? C_ID_ZERO : r_restore_pos;
                rn_stall       = !rst;
                w_state_next   = ST_DRAIN;
            end
            ST_DRAIN: begin
                rn_stall     = !rst;
                w_state_next = ST_NORMAL;
            end
            default: begin
                w_state_next = ST_NORMAL;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign br_alloc_id     = r_tail;
    assign rn_checkpoint   = w_grant;
    assign busy_mask       = r_busy;
    assign free_count      = C_DEPTH - w_busy_cnt;
    assign err_bad_resolve = r_err;

endmodule : tboom_checkpoint_ctrl
`default_nettype wire

// File: tb/tb_tboom_checkpoint_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tboom_checkpoint_ctrl
// Purpose  : Self-checking bench for tboom_checkpoint_ctrl. A queue of
//            in-flight branches (program order) serves as the reference;
//            directed scenarios are followed by a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tboom_checkpoint_ctrl;

    localparam int DEPTH = 8;
    localparam int IDW   = 3;

    logic           clk;
    logic           rst;
    logic           br_alloc_valid;
    logic           br_alloc_ready;
    logic [IDW-1:0] br_alloc_id;
    logic           br_resolve_valid;
    logic [IDW-1:0] br_resolve_id;
    logic           br_resolve_mispredict;
    logic           rn_checkpoint;
    logic           rn_restore;
    logic [IDW-1:0] rn_restore_pos;
    logic           rn_stall;
    logic [DEPTH-1:0] busy_mask;
    logic [IDW:0]   free_count;
    logic           err_bad_resolve;

    int n_assert = 0;
    int n_fail   = 0;

    tboom_checkpoint_ctrl #(.CHECKPOINT_DEPTH(DEPTH)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .br_alloc_valid        (br_alloc_valid),
        .br_alloc_ready        (br_alloc_ready),
        .br_alloc_id           (br_alloc_id),
        .br_resolve_valid      (br_resolve_valid),
        .br_resolve_id         (br_resolve_id),
        .br_resolve_mispredict (br_resolve_mispredict),
        .rn_checkpoint         (rn_checkpoint),
        .rn_restore            (rn_restore),
        .rn_restore_pos        (rn_restore_pos),
        .rn_stall              (rn_stall),
        .busy_mask             (busy_mask),
        .free_count            (free_count),
        .err_bad_resolve       (err_bad_resolve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: in-flight branches oldest-first, next id to hand out,
    // recovery phase (0 normal, 1 restore pulse, 2 drain), latched position.
    // ------------------------------------------------------------------------
    typedef struct {
        int id;
        bit res;
    } ent_t;

    ent_t m_q[$];
    int   m_tail;
    int   m_phase;
    int   m_rpos;
    bit   m_err;

    task automatic model_reset();
        m_q.delete();
        m_tail  = 0;
        m_phase = 0;
        m_rpos  = 0;
        m_err   = 1'b0;
    endtask

    function automatic int find_pos(input int id);
        for (int k = 0; k < m_q.size(); k++) begin
            if (m_q[k].id == id) return k;
        end
        return -1;
    endfunction

    function automatic logic [DEPTH-1:0] model_busy();
        logic [DEPTH-1:0] m;
        m = '0;
        foreach (m_q[k]) m[m_q[k].id] = 1'b1;
        return m;
    endfunction

    function automatic bit model_ready(input bit rv, input bit mp);
        return (m_phase == 0) && (m_q.size() < DEPTH) && !(rv && mp);
    endfunction

    task automatic model_step(input bit av, input bit rv, input int rid, input bit mp);
        bit retire;
        bit grant;
        int pos;
        grant  = av && model_ready(rv, mp);
        retire = (m_q.size() > 0) && m_q[0].res;
        pos    = find_pos(rid);
        if (m_phase == 0 && rv && pos < 0) m_err = 1'b1;
        if (m_phase == 0 && rv && mp && pos >= 0) begin
            while (m_q.size() > pos) void'(m_q.pop_back());
            if (pos != 0 && retire) void'(m_q.pop_front());
            m_tail  = rid;
            m_rpos  = rid;
            m_phase = 1;
        end else begin
            if (m_phase == 0 && rv && pos >= 0) m_q[pos].res = 1'b1;
            if (retire) void'(m_q.pop_front());
            if (m_phase != 0) m_phase = (m_phase == 1) ? 2 : 0;
        end
        if (grant) begin
            m_q.push_back('{id: m_tail, res: 1'b0});
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        br_alloc_valid        = 1'b0;
        br_resolve_valid      = 1'b0;
        br_resolve_id         = '0;
        br_resolve_mispredict = 1'b0;
    endtask

    // One clock: drive, compare every output against the model, advance.
    task automatic cyc(input bit av, input bit rv, input int rid, input bit mp, output int gid);
        bit mr;
        logic [31:0] rid_v;
        rid_v                 = rid;
        br_alloc_valid        = av;
        br_resolve_valid      = rv;
        br_resolve_id         = rid_v[IDW-1:0];
        br_resolve_mispredict = mp;
        #2;
        mr = model_ready(rv, mp);
        chk("alloc_ready", br_alloc_ready, mr);
        chk("alloc_id", br_alloc_id, m_tail);
        chk("rn_checkpoint", rn_checkpoint, av && mr);
        chk("rn_restore", rn_restore, m_phase == 1);
        chk("rn_restore_pos", rn_restore_pos, (m_phase == 1) ? m_rpos : 0);
        chk("rn_stall", rn_stall, m_phase != 0);
        chk("busy_mask", busy_mask, model_busy());
        chk("free_count", free_count, DEPTH - m_q.size());
        chk("err_bad_resolve", err_bad_resolve, m_err);
        gid = br_alloc_id;
        @(posedge clk);
        #1;
        model_step(av, rv, rid, mp);
        idle_inputs();
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        br_alloc_valid = 1'b1;
        #1;
        chk("rst_alloc_ready", br_alloc_ready, 0);
        chk("rst_rn_checkpoint", rn_checkpoint, 0);
        chk("rst_rn_restore", rn_restore, 0);
        chk("rst_rn_stall", rn_stall, 0);
        @(posedge clk);
        #1;
        chk("rst_free_count", free_count, DEPTH);
        chk("rst_busy_mask", busy_mask, 0);
        chk("rst_err", err_bad_resolve, 0);
        rst = 1'b0;
        idle_inputs();
        model_reset();
        #1;
    endtask

    task automatic idle_cycles(input int n);
        int g;
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, g);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int g;
        int g0, g1, g2;
        int rid;
        bit av, rv, mp;

        rst = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;

        // Three allocations after reset release
        do_reset();
        cyc(1, 0, 0, 0, g0);
        cyc(1, 0, 0, 0, g1);
        cyc(1, 0, 0, 0, g2);
        chk("t1_id0", g0, 0);
        chk("t1_id1", g1, 1);
        chk("t1_id2", g2, 2);
        chk("t1_free", free_count, 5);
        chk("t1_busy", busy_mask, 8'h07);

        // Full ring, then a correct resolve of the head re-opens allocation
        do_reset();
        for (int k = 0; k < DEPTH; k++) cyc(1, 0, 0, 0, g);
        chk("t2_full_ready", br_alloc_ready, 0);
        chk("t2_full_free", free_count, 0);
        cyc(0, 1, 0, 0, g);
        chk("t2_ready_after1", br_alloc_ready, 0);
        cyc(0, 0, 0, 0, g);
        chk("t2_ready_after2", br_alloc_ready, 1);

        // Mispredict in the middle of the ring
        do_reset();
        for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0, g);
        cyc(0, 1, 2, 1, g);
        chk("t3_restore", rn_restore, 1);
        chk("t3_restore_pos", rn_restore_pos, 2);
        chk("t3_stall", rn_stall, 1);
        chk("t3_busy", busy_mask, 8'h03);
        cyc(0, 0, 0, 0, g);
        chk("t3_drain_restore", rn_restore, 0);
        chk("t3_drain_stall", rn_stall, 1);
        cyc(0, 0, 0, 0, g);
        chk("t3_normal_stall", rn_stall, 0);
        chk("t3_next_id", br_alloc_id, 2);

        // Tail wrap and wrap-aware flush
        do_reset();
        for (int k = 0; k < DEPTH; k++) cyc(1, 0, 0, 0, g);
        for (int k = 0; k < 6; k++) cyc(0, 1, k, 0, g);
        cyc(0, 0, 0, 0, g);
        chk("t4_free", free_count, 6);
        chk("t4_busy_retired", busy_mask, 8'hC0);
        cyc(1, 0, 0, 0, g0);
        cyc(1, 0, 0, 0, g1);
        chk("t4_wrap_id0", g0, 0);
        chk("t4_wrap_id1", g1, 1);
        chk("t4_busy_wrapped", busy_mask, 8'hC3);
        cyc(0, 1, 7, 1, g);
        chk("t4_busy_flushed", busy_mask, 8'h40);
        idle_cycles(2);

        // Mispredict beats allocation; resolve to a free slot is flagged
        cyc(1, 1, 6, 1, g);
        chk("t5_busy_empty", busy_mask, 8'h00);
        idle_cycles(2);
        cyc(1, 0, 0, 0, g0);
        chk("t5_id", g0, 6);
        cyc(0, 1, 5, 0, g);
        chk("t5_err", err_bad_resolve, 1);
        chk("t5_busy_kept", busy_mask, 8'h40);

        // Head mispredict with a full ring frees everything
        do_reset();
        for (int k = 0; k < DEPTH; k++) cyc(1, 0, 0, 0, g);
        cyc(0, 1, 0, 1, g);
        idle_cycles(2);
        chk("t6_free", free_count, DEPTH);
        chk("t6_busy", busy_mask, 8'h00);

        // Reset during RESTORE aborts recovery
        do_reset();
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, g);
        cyc(0, 1, 1, 1, g);
        chk("t7_in_restore", rn_restore, 1);
        rst = 1'b1;
        #1;
        chk("t7_rst_restore", rn_restore, 0);
        chk("t7_rst_stall", rn_stall, 0);
        chk("t7_rst_free", free_count, DEPTH);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        idle_cycles(3);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 500; n++) begin
            av = ($urandom % 4) != 0;
            rv = ($urandom % 2) != 0;
            mp = ($urandom % 6) == 0;
            if (m_q.size() > 0 && ($urandom % 5) != 0)
                rid = m_q[$urandom % m_q.size()].id;
            else
                rid = $urandom_range(0, DEPTH - 1);
            cyc(av, rv, rid, mp, g);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_tboom_checkpoint_ctrl
`default_nettype wire

// File: doc/tboom_checkpoint_ctrl.md
TBOOM_CHECKPOINT_CTRL -- requirements
Module: tboom_checkpoint_ctrl

Interface
REQ-001 Parameter CHECKPOINT_DEPTH, default 8, number of rename-map checkpoint slots (power of two, >=2).
REQ-002 Parameter CKPT_ID_WIDTH, default $clog2(CHECKPOINT_DEPTH), slot index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 br_alloc_valid  input  1  dispatch requests a checkpoint for a branch this cycle.
REQ-006 br_alloc_ready  output  1  checkpoint grant possible this cycle.
REQ-007 br_alloc_id  output  CKPT_ID_WIDTH  slot granted (valid when valid&&ready).
REQ-008 br_resolve_valid  input  1  branch resolution event.
REQ-009 br_resolve_id  input  CKPT_ID_WIDTH  slot of resolving branch.
REQ-010 br_resolve_mispredict  input  1  resolution is a mispredict.
REQ-011 rn_checkpoint  output  1  drives rename unit checkpoint strobe.
REQ-012 rn_restore  output  1  drives rename unit restore strobe.
REQ-013 rn_restore_pos  output  CKPT_ID_WIDTH  drives rename unit checkpoint_restore_pos.
REQ-014 rn_stall  output  1  front-end rename stall during recovery.
REQ-015 busy_mask  output  CHECKPOINT_DEPTH  bit i set = slot i allocated.
REQ-016 free_count  output  CKPT_ID_WIDTH+1  free slots, 0..CHECKPOINT_DEPTH.
REQ-017 err_bad_resolve  output  1  sticky: resolve targeted a non-busy slot.

Function
REQ-018 Slots form a ring: allocation at tail, oldest at head; program order = ring order.
REQ-019 br_alloc_ready = state NORMAL && free_count!=0 && !(br_resolve_valid && br_resolve_mispredict) && !rst.
REQ-020 br_alloc_id = tail; rn_checkpoint = br_alloc_valid && br_alloc_ready, same cycle (zero latency).
REQ-021 On grant: busy[tail] set, resolved[tail] cleared, tail increments mod CHECKPOINT_DEPTH.
REQ-022 Correct resolve (valid, !mispredict, busy[id]) in NORMAL: resolved[id] set next edge.
REQ-023 Head retire: when busy[head]&&resolved[head], clear busy[head], head++ mod depth; at most one slot per cycle.
REQ-024 free_count = CHECKPOINT_DEPTH minus busy slots; grant and retire in same cycle leave it unchanged.
REQ-025 FSM states NORMAL, RESTORE, DRAIN.
REQ-026 NORMAL -> RESTORE on mispredict resolve with busy[id]: next edge clear busy for id and every slot from id to tail-1 (wrap-aware), set tail=id, latch restore_pos=id.
REQ-027 RESTORE: rn_restore=1, rn_restore_pos=restore_pos, rn_stall=1 for exactly one cycle, then DRAIN.
REQ-028 DRAIN: rn_stall=1 for exactly one cycle, then NORMAL.
REQ-029 rn_restore=0 and rn_restore_pos=0 in NORMAL and DRAIN; rn_stall=0 in NORMAL.
REQ-030 Resolves arriving in RESTORE/DRAIN are ignored, no state change.
REQ-031 Resolve to non-busy slot: ignored, err_bad_resolve set until reset.
REQ-032 Mispredict on head slot with ring full: all slots freed, free_count=CHECKPOINT_DEPTH after recovery.
REQ-033 Mispredict and alloc request same cycle: mispredict wins, no grant, rn_checkpoint=0.
REQ-034 Mispredict and head retire same cycle: both applied; slot id itself is freed by the mispredict regardless.

Reset
REQ-035 On rst: state NORMAL, head=tail=0, busy/resolved all 0, free_count=CHECKPOINT_DEPTH, restore_pos=0, err_bad_resolve=0.
REQ-036 While rst high: br_alloc_ready, rn_checkpoint, rn_restore, rn_stall = 0; reset mid-recovery aborts to NORMAL with no restore pulse.

Structure
REQ-037 Shared package tboom_rmt_pkg holds the FSM state enum and the default CHECKPOINT_DEPTH constant.
REQ-038 Single module; no sub-module is natural.

Verification
REQ-039 Reset release, alloc 3 cycles -> ids 0,1,2, rn_checkpoint high each cycle, free_count 8->5, busy_mask=8'h07.
REQ-040 Alloc 8 back-to-back -> 9th cycle br_alloc_ready=0, free_count=0; correct resolve id 0 -> ready=1 two cycles later.
REQ-041 Alloc ids 0..4, mispredict id 2 -> next cycle rn_restore=1, rn_restore_pos=2, rn_stall=1; then 1 stall cycle; busy_mask=8'h03, next alloc id=2.
REQ-042 Tail wrap: alloc 8, retire 0..5, alloc 2 -> ids 0,1; mispredict id 7 frees slots 7,0,1; busy_mask=8'h40.
REQ-043 Mispredict plus alloc_valid same cycle -> no grant; resolve id 5 when non-busy -> err_bad_resolve=1, busy_mask unchanged.
REQ-044 Assert rst during RESTORE -> rn_restore/rn_stall drop immediately, free_count=8, no further restore pulse.
